// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i core: word size, PC step, canonical NOP,
// the PC-tagged fetch buffer entry and the fetch FSM state type.
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;
   localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] ins;
   } fetch_entry_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   // Instruction addresses are always word aligned; low two bits are dropped.
   function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding PC-tagged instruction words between the
// memory response port and decode. Flush empties it and beats a push.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W-1:0] wrPtr_q;
   logic [CNT_W-1:0] count_q;
   logic             doPush;
   logic             doPop;

   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign rdata  = mem_q[rdPtr_q];
   // A full FIFO may still take a push when the head leaves in the same cycle.
   assign doPush = push & (~full | pop);
   assign doPop  = pop & ~empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH
   // is a power of two, and a flush returns everything to the empty state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else if (flush) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (doPush && !flush) mem_q[wrPtr_q] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned sequential requests under a
// credit limit, tags returned words with their PC, buffers them for decode
// and squashes everything in flight when execute redirects the PC.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [31:0] ins,
   output logic [31:0] ins_pc
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SUM_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetchPc_q, fetchPc_d;
   logic [XLEN-1:0] tagPc_q, tagPc_d;
   logic [XLEN-1:0] lastPc_q;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] fifoCount;
   logic [SUM_W-1:0] creditUsed;
   logic            fifoFull, fifoEmpty, fifoPush, fifoPop;
   logic            reqFire, rspKeep;
   fetch_entry_t    pushEntry, headEntry;

   assign creditUsed = SUM_W'(outstanding_q) + SUM_W'(fifoCount);
   assign imem_addr  = fetchPc_q;
   assign pushEntry  = '{pc: tagPc_q, ins: imem_rdata};
   assign ins_valid  = ~fifoEmpty;
   assign ins        = fifoEmpty ? NOP : headEntry.ins;
   assign ins_pc     = fifoEmpty ? lastPc_q : headEntry.pc;
   assign fifoPop    = ins_valid & ins_ready;
   assign fifoPush   = rspKeep & (~fifoFull | fifoPop);

   // Request gating, handshake accounting and redirect handling. Outstanding
   // counts every response still owed, including those marked for dropping,
   // so a word that is kept always finds a free FIFO slot.
   always_comb begin
      state_d       = state_q;
      fetchPc_d     = fetchPc_q;
      tagPc_d       = tagPc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      imem_req_valid = (state_q == RUN) && !redirect_valid &&
                       (creditUsed < SUM_W'(FIFO_DEPTH));
      reqFire = imem_req_valid & imem_req_ready;
      rspKeep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

      if (state_q == BOOT) state_d = RUN;

      if (reqFire) begin
         fetchPc_d     = fetchPc_q + PC_INC;
         outstanding_d = outstanding_d + CNT_ONE;
      end

      if (imem_rsp_valid) begin
         outstanding_d = outstanding_d - CNT_ONE;
         if (drop_q != '0) drop_d = drop_q - CNT_ONE;
      end

      if (rspKeep) tagPc_d = tagPc_q + PC_INC;

      if (redirect_valid) begin
         fetchPc_d = alignPc(redirect_pc);
         tagPc_d   = alignPc(redirect_pc);
         drop_d    = outstanding_d;
      end
   end

   // State registers; ins_pc keeps showing the last head once the buffer drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         fetchPc_q     <= RESET_PC;
         tagPc_q       <= RESET_PC;
         lastPc_q      <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         state_q       <= state_d;
         fetchPc_q     <= fetchPc_d;
         tagPc_q       <= tagPc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         if (!fifoEmpty) lastPc_q <= headEntry.pc;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2 * XLEN)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifoPush),
      .pop   (fifoPop),
      .flush (redirect_valid),
      .wdata (pushEntry),
      .rdata (headEntry),
      .count (fifoCount),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model answers requests in order
// with variable latency, and a reference model predicts the instruction
// stream decode should see, including squashing on redirect and reset.
module tb_fetch_unit;
   import rv32i_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        ins_valid;
   logic        ins_ready = 1'b0;
   logic [31:0] ins;
   logic [31:0] ins_pc;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pendQ[$];
   logic [31:0] expPcQ[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          tbOut = 0;
   int          tbBuf = 0;
   int          tbDrop = 0;
   logic [31:0] expReqPc = RESET_PC;
   logic [31:0] expTag = RESET_PC;
   logic [31:0] lastPc = '0;
   bit          bootCycle = 1'b0;

   int          readyPct = 100;
   int          insReadyPct = 100;
   int          latMin = 1;
   int          latMax = 1;
   int          redirPermille = 0;
   bit          forceRedir = 1'b0;
   logic [31:0] forceRedirPc = '0;

   fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ins_valid      (ins_valid),
      .ins_ready      (ins_ready),
      .ins            (ins),
      .ins_pc         (ins_pc)
   );

   // Free-running clock and a cycle counter used to schedule memory replies.
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Memory contents: three known words at the bottom, a hash elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'hff70_0293;
         32'h0000_0004: return 32'h0070_0313;
         32'h0000_0008: return 32'h4062_8233;
         default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model and monitor, sampled mid-cycle. Expected instructions are
   // pushed when a kept response arrives and popped when decode takes one.
   always @(negedge clk) begin
      bit reqExp;
      if (rst_n) begin
         reqExp = !bootCycle && !redirect_valid && (tbOut + tbBuf < DEPTH);
         checkOutput("req_valid", 32'(imem_req_valid), 32'(reqExp));
         checkOutput("imem_addr", imem_addr, expReqPc);
         checkOutput("ins_valid", 32'(ins_valid), 32'(tbBuf > 0));
         if (tbBuf > 0) begin
            checkOutput("ins", ins, memWord(expPcQ[0]));
            checkOutput("ins_pc", ins_pc, expPcQ[0]);
            lastPc = expPcQ[0];
            if (ins_ready) begin
               void'(expPcQ.pop_front());
               tbBuf--;
            end
         end else begin
            checkOutput("ins_nop", ins, NOP);
            checkOutput("ins_pc_hold", ins_pc, lastPc);
         end
         if (imem_req_valid && imem_req_ready) begin
            pendQ.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(latMin, latMax))});
            tbOut++;
            expReqPc = expReqPc + 32'd4;
         end
         if (imem_rsp_valid) begin
            tbOut--;
            if (tbDrop > 0) tbDrop--;
            else if (!redirect_valid) begin
               expPcQ.push_back(expTag);
               expTag = expTag + 32'd4;
               tbBuf++;
            end
         end
         if (redirect_valid) begin
            expPcQ.delete();
            tbBuf    = 0;
            tbDrop   = tbOut;
            expReqPc = redirect_pc & ~32'h3;
            expTag   = redirect_pc & ~32'h3;
         end
         bootCycle = 1'b0;
      end
   end

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         imem_req_ready = ($urandom_range(0, 99) < readyPct);
         ins_ready      = ($urandom_range(0, 99) < insReadyPct);
         if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = memWord(pendQ[0].addr);
            void'(pendQ.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rdata     = $urandom;
         end
         if (forceRedir) begin
            redirect_valid = 1'b1;
            redirect_pc    = forceRedirPc;
            forceRedir     = 1'b0;
         end else if ($urandom_range(0, 999) < redirPermille) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
         end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
         end
      end
   endtask

   task automatic doReset(input int holdCycles);
      rst_n          = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      ins_ready      = 1'b0;
      #1;
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_imem_addr", imem_addr, RESET_PC);
      checkOutput("rst_ins_valid", 32'(ins_valid), 32'd0);
      checkOutput("rst_ins", ins, NOP);
      checkOutput("rst_ins_pc", ins_pc, 32'd0);
      pendQ.delete();
      expPcQ.delete();
      tbOut    = 0;
      tbBuf    = 0;
      tbDrop   = 0;
      expReqPc = RESET_PC;
      expTag   = RESET_PC;
      lastPc   = '0;
      repeat (holdCycles) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      bootCycle = 1'b1;
   endtask

   task automatic redirectTo(input logic [31:0] pc, input int after);
      forceRedirPc = pc;
      forceRedir   = 1'b1;
      applyStimulus(after);
   endtask

   // Directed scenarios first, then long randomized traffic with resets.
   initial begin
      #2;
      doReset(2);
      applyStimulus(20);

      insReadyPct = 0;
      applyStimulus(6);
      insReadyPct = 100;
      applyStimulus(10);

      latMin = 3;
      latMax = 3;
      applyStimulus(8);
      redirectTo(32'h0000_0100, 15);

      latMin = 1;
      latMax = 1;
      applyStimulus(5);
      redirectTo(32'h0000_0103, 10);
      redirectTo(32'hFFFF_FFFC, 12);

      readyPct      = 70;
      insReadyPct   = 70;
      latMin        = 1;
      latMax        = 4;
      redirPermille = 30;
      applyStimulus(1500);

      doReset(2);
      applyStimulus(300);
      doReset(1);
      readyPct    = 100;
      insReadyPct = 100;
      latMin      = 1;
      latMax      = 1;
      applyStimulus(300);

      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
